sap_control_sequencer: RTL and testbench
========================================

Name: sap_control_sequencer

Overview:
- Parametrised fetch/decode/execute sequencer for the SAP_U datapath (reg A, reg B, ALU, RAM/MAR, shared bus).
- Owns the program counter (PC), instruction register (IR), carry/zero flags and the T-state machine.
- Drives every datapath load/enable strobe, replacing hand-driven strobes.
- Additions: variable-length instructions, STA/LDI/jumps/conditional jumps, run/halt control, and width/depth parametrisation.

Parameters:
- OPCODE_WIDTH, 4: opcode field, upper bits of the instruction word.
- ADDR_WIDTH, 4: operand/RAM address field, lower bits; PC width.
- DATA_WIDTH, 8: bus width. Must equal OPCODE_WIDTH+ADDR_WIDTH; an elaboration error is raised otherwise.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- run  in  1  level; 1 = execute, 0 = stop at the next instruction boundary
- bus_in  in  DATA_WIDTH  current bus value (IR load, jump target)
- alu_carry  in  1  ALU carry-out
- alu_zero  in  1  ALU result == 0
- pc_out  out  ADDR_WIDTH  PC value, zero-extended onto the bus by the top level when pc_enable=1
- ir_operand  out  DATA_WIDTH  IR[ADDR_WIDTH-1:0] zero-extended; bus source when ir_enable=1
- pc_enable, ir_enable, ram_output_enable, reg_a_enable, alu_enable  out  1 each  bus drivers
- mar_load, ir_load, ram_write_enable, reg_a_load, reg_b_load, out_load  out  1 each  load strobes
- alu_subtract  out  1  ALU mode
- opcode  out  OPCODE_WIDTH  IR[DATA_WIDTH-1:ADDR_WIDTH]
- tstate  out  3  current state encoding
- halted  out  1  1 while in HALT
- flag_c, flag_z  out  1 each  latched flags

Behaviour:
- States: IDLE=0, T0..T4 = 1..5, HALT=7.
- All strobes are decoded combinationally from the registered state, IR and flags.
- Reset, asynchronous: state=IDLE, PC=0, IR=0, flags=0. All strobes, halted and alu_subtract read 0 while reset is high and in IDLE.
- IDLE: all strobes 0. run=1 -> T0 on the next edge.
- T0: pc_enable, mar_load.
- T1: ram_output_enable, ir_load. IR<=bus_in and PC<=PC+1 at the end of T1. PC wraps from 2^ADDR_WIDTH-1 to 0.
- Execute (T2 onward) by opcode. "Last" = the next state is T0 if run=1, else IDLE.
  - 0 NOP: T2 no strobes; last.
  - 1 LDA: T2 ir_enable+mar_load. T3 ram_output_enable+reg_a_load; last.
  - 2 ADD: T2 ir_enable+mar_load. T3 ram_output_enable+reg_b_load. T4 alu_enable+reg_a_load, flags<=(alu_carry, alu_zero); last.
  - 3 SUB: as ADD; alu_subtract=1 in T3 and T4.
  - 4 STA: T2 ir_enable+mar_load. T3 reg_a_enable+ram_write_enable; last.
  - 5 LDI: T2 ir_enable+reg_a_load; last.
  - 6 JMP: T2 ir_enable, PC<=bus_in[ADDR_WIDTH-1:0]; last.
  - 7 JC / 8 JZ: T2 as JMP if flag_c / flag_z=1, else no strobes; last either way.
  - 14 OUT: T2 reg_a_enable+out_load; last.
  - 15 HLT: T2 no strobes -> HALT.
  - Other opcodes behave as NOP.
- HALT: halted=1, all strobes 0. Only reset exits; run is ignored.
- run falling mid-instruction: the instruction completes, then IDLE. The PC is kept, so the next run resumes at the next instruction.
- Flags change only on ADD/SUB T4.
- Invariant, asserted in the bench: at most one bus driver (pc_enable, ir_enable, ram_output_enable, reg_a_enable, alu_enable) high in any cycle.
- JMP at end of T2 and the T1 increment never coincide.

Decomposition:
- Shared package sap_pkg holds:
  - opcode localparams: NOP, LDA, ADD, SUB, STA, LDI, JMP, JC, JZ, OUT, HLT;
  - state encodings: IDLE, T0..T4, HALT;
  - default widths.
- Sub-module sap_program_counter (ADDR_WIDTH) has async reset, increment and load ports; its load has priority over increment.

Test Plan:
- Reset + run: reset pulse, run=1, RAM[0]=LDI 5 (0x55) -> tstate sequence 1,2,3 then 1; reg_a_load high in T2 with ir_operand=0x05; PC=1.
- ADD flags: RAM[0]=LDA 0xE, RAM[1]=ADD 0xF, RAM[0xE]=0xFF, RAM[0xF]=0x01 -> T4 of ADD asserts alu_enable+reg_a_load; flag_c=1, flag_z=1 after T4.
- Conditional jump: after the ADD case, RAM[2]=JZ 0x7 -> PC=7 at T0. Repeat with flag_z=0 -> PC=3.
- Halt/run: program ending in HLT (0xF0) -> halted=1, tstate=7, strobes 0 for 20 cycles regardless of run. Separately, drop run during ADD T3 -> ADD completes, then tstate=0 and PC is held.
- PC wrap: ADDR_WIDTH=4, NOP at every address -> PC goes 15 -> 0 with no halt.
- Async reset mid-op: assert reset between edges during STA T3 -> state/PC/IR/flags are 0 immediately and ram_write_enable drops without waiting for clk.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP_U control sequencer: default widths, opcodes
// and the T-state encoding.
package sap_pkg;

   localparam int unsigned DEF_OPCODE_WIDTH = 4;
   localparam int unsigned DEF_ADDR_WIDTH   = 4;
   localparam int unsigned DEF_DATA_WIDTH   = 8;

   localparam int unsigned OP_NOP = 0;
   localparam int unsigned OP_LDA = 1;
   localparam int unsigned OP_ADD = 2;
   localparam int unsigned OP_SUB = 3;
   localparam int unsigned OP_STA = 4;
   localparam int unsigned OP_LDI = 5;
   localparam int unsigned OP_JMP = 6;
   localparam int unsigned OP_JC  = 7;
   localparam int unsigned OP_JZ  = 8;
   localparam int unsigned OP_OUT = 14;
   localparam int unsigned OP_HLT = 15;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T0   = 3'd1,
      ST_T1   = 3'd2,
      ST_T2   = 3'd3,
      ST_T3   = 3'd4,
      ST_T4   = 3'd5,
      ST_HALT = 3'd7
   } state_t;

endpackage

// File: rtl/sap_program_counter.sv
// Program counter: asynchronous clear, jump load wins over increment,
// wraps naturally at 2^ADDR_WIDTH.
module sap_program_counter #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inc,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] load_value,
   output logic [ADDR_WIDTH-1:0] pc
);

   // PC register: load has priority, otherwise optional increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= '0;
      end else if (load) begin
         pc <= load_value;
      end else if (inc) begin
         pc <= pc + ADDR_WIDTH'(1);
      end
   end

endmodule

// File: rtl/sap_control_sequencer.sv
// Fetch/decode/execute sequencer for the SAP_U datapath. Owns PC, IR, flags
// and the T-state machine; every datapath strobe is decoded from state/IR/flags.
//
//   state | meaning
//   IDLE  | stopped at an instruction boundary, waiting for run
//   T0    | PC onto bus, load MAR
//   T1    | RAM onto bus, load IR, advance PC
//   T2    | first execute step (operand / jump / single-step ops)
//   T3    | second execute step (LDA, ADD, SUB, STA)
//   T4    | ALU result into A, flags captured (ADD, SUB)
//   HALT  | stopped by HLT; only reset leaves
module sap_control_sequencer
   import sap_pkg::*;
#(
   parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    run,
   input  logic [DATA_WIDTH-1:0]   bus_in,
   input  logic                    alu_carry,
   input  logic                    alu_zero,
   output logic [ADDR_WIDTH-1:0]   pc_out,
   output logic [DATA_WIDTH-1:0]   ir_operand,
   output logic                    pc_enable,
   output logic                    ir_enable,
   output logic                    ram_output_enable,
   output logic                    reg_a_enable,
   output logic                    alu_enable,
   output logic                    mar_load,
   output logic                    ir_load,
   output logic                    ram_write_enable,
   output logic                    reg_a_load,
   output logic                    reg_b_load,
   output logic                    out_load,
   output logic                    alu_subtract,
   output logic [OPCODE_WIDTH-1:0] opcode,
   output logic [2:0]              tstate,
   output logic                    halted,
   output logic                    flag_c,
   output logic                    flag_z
);

   if (DATA_WIDTH != OPCODE_WIDTH + ADDR_WIDTH) begin : g_width_check
      $error("sap_control_sequencer: DATA_WIDTH must equal OPCODE_WIDTH + ADDR_WIDTH");
   end

   localparam logic [OPCODE_WIDTH-1:0] C_NOP = OPCODE_WIDTH'(OP_NOP);
   localparam logic [OPCODE_WIDTH-1:0] C_LDA = OPCODE_WIDTH'(OP_LDA);
   localparam logic [OPCODE_WIDTH-1:0] C_ADD = OPCODE_WIDTH'(OP_ADD);
   localparam logic [OPCODE_WIDTH-1:0] C_SUB = OPCODE_WIDTH'(OP_SUB);
   localparam logic [OPCODE_WIDTH-1:0] C_STA = OPCODE_WIDTH'(OP_STA);
   localparam logic [OPCODE_WIDTH-1:0] C_LDI = OPCODE_WIDTH'(OP_LDI);
   localparam logic [OPCODE_WIDTH-1:0] C_JMP = OPCODE_WIDTH'(OP_JMP);
   localparam logic [OPCODE_WIDTH-1:0] C_JC  = OPCODE_WIDTH'(OP_JC);
   localparam logic [OPCODE_WIDTH-1:0] C_JZ  = OPCODE_WIDTH'(OP_JZ);
   localparam logic [OPCODE_WIDTH-1:0] C_OUT = OPCODE_WIDTH'(OP_OUT);
   localparam logic [OPCODE_WIDTH-1:0] C_HLT = OPCODE_WIDTH'(OP_HLT);

   state_t                state, next_state, last_state;
   logic [DATA_WIDTH-1:0] ir;
   logic                  pc_inc, pc_load, flag_update;

   assign opcode     = ir[DATA_WIDTH-1:ADDR_WIDTH];
   assign ir_operand = DATA_WIDTH'(ir[ADDR_WIDTH-1:0]);
   assign tstate     = state;
   assign halted     = (state == ST_HALT);

   sap_program_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc (
      .clk        (clk),
      .reset      (reset),
      .inc        (pc_inc),
      .load       (pc_load),
      .load_value (bus_in[ADDR_WIDTH-1:0]),
      .pc         (pc_out)
   );

   // State, instruction register and flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         ir     <= '0;
         flag_c <= 1'b0;
         flag_z <= 1'b0;
      end else begin
         state <= next_state;
         if (ir_load) begin
            ir <= bus_in;
         end
         if (flag_update) begin
            flag_c <= alu_carry;
            flag_z <= alu_zero;
         end
      end
   end

   // Next-state and strobe decode from registered state, IR and flags.
   always_comb begin
      next_state        = state;
      last_state        = run ? ST_T0 : ST_IDLE;
      pc_enable         = 1'b0;
      ir_enable         = 1'b0;
      ram_output_enable = 1'b0;
      reg_a_enable      = 1'b0;
      alu_enable        = 1'b0;
      mar_load          = 1'b0;
      ir_load           = 1'b0;
      ram_write_enable  = 1'b0;
      reg_a_load        = 1'b0;
      reg_b_load        = 1'b0;
      out_load          = 1'b0;
      alu_subtract      = 1'b0;
      pc_inc            = 1'b0;
      pc_load           = 1'b0;
      flag_update       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (run) next_state = ST_T0;
         end
         ST_T0: begin
            pc_enable  = 1'b1;
            mar_load   = 1'b1;
            next_state = ST_T1;
         end
         ST_T1: begin
            ram_output_enable = 1'b1;
            ir_load           = 1'b1;
            pc_inc            = 1'b1;
            next_state        = ST_T2;
         end
         ST_T2: begin
            next_state = last_state;
            case (opcode)
               C_NOP: ;
               C_LDA, C_ADD, C_SUB, C_STA: begin
                  ir_enable  = 1'b1;
                  mar_load   = 1'b1;
                  next_state = ST_T3;
               end
               C_LDI: begin
                  ir_enable  = 1'b1;
                  reg_a_load = 1'b1;
               end
               C_JMP: begin
                  ir_enable = 1'b1;
                  pc_load   = 1'b1;
               end
               C_JC: begin
                  ir_enable = flag_c;
                  pc_load   = flag_c;
               end
               C_JZ: begin
                  ir_enable = flag_z;
                  pc_load   = flag_z;
               end
               C_OUT: begin
                  reg_a_enable = 1'b1;
                  out_load     = 1'b1;
               end
               C_HLT: next_state = ST_HALT;
               default: ;
            endcase
         end
         ST_T3: begin
            next_state = last_state;
            case (opcode)
               C_LDA: begin
                  ram_output_enable = 1'b1;
                  reg_a_load        = 1'b1;
               end
               C_ADD, C_SUB: begin
                  ram_output_enable = 1'b1;
                  reg_b_load        = 1'b1;
                  alu_subtract      = (opcode == C_SUB);
                  next_state        = ST_T4;
               end
               C_STA: begin
                  reg_a_enable     = 1'b1;
                  ram_write_enable = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T4: begin
            alu_enable   = 1'b1;
            reg_a_load   = 1'b1;
            flag_update  = 1'b1;
            alu_subtract = (opcode == C_SUB);
            next_state   = last_state;
         end
         ST_HALT: next_state = ST_HALT;
         default: next_state = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: a small SAP_U datapath (RAM, MAR, A, B, ALU,
// bus mux) is wrapped around the sequencer; per-cycle expectation tables are
// pushed to a scoreboard queue as run is driven and popped for comparison.
module tb_sap_control_sequencer;

   localparam logic [12:0] PCE  = 13'h1000;
   localparam logic [12:0] IRE  = 13'h0800;
   localparam logic [12:0] ROE  = 13'h0400;
   localparam logic [12:0] RAE  = 13'h0200;
   localparam logic [12:0] ALE  = 13'h0100;
   localparam logic [12:0] MARL = 13'h0080;
   localparam logic [12:0] IRL  = 13'h0040;
   localparam logic [12:0] RWE  = 13'h0020;
   localparam logic [12:0] RAL  = 13'h0010;
   localparam logic [12:0] RBL  = 13'h0008;
   localparam logic [12:0] HLTD = 13'h0001;

   typedef struct {
      logic        run;
      logic [2:0]  ts;
      logic [12:0] strb;
      logic [3:0]  pc;
      logic [1:0]  flags;
      logic        oc;
      logic [7:0]  opnd;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       run = 1'b0;
   logic [7:0] bus_in;
   logic       alu_carry, alu_zero;
   logic [3:0] pc_out;
   logic [7:0] ir_operand;
   logic       pc_enable, ir_enable, ram_output_enable, reg_a_enable, alu_enable;
   logic       mar_load, ir_load, ram_write_enable, reg_a_load, reg_b_load, out_load;
   logic       alu_subtract, halted, flag_c, flag_z;
   logic [3:0] opcode;
   logic [2:0] tstate;

   logic [7:0] prog [16];
   logic [7:0] ram  [16];
   logic [3:0] mar;
   logic [7:0] reg_a, reg_b;
   logic [8:0] alu_sum;
   logic [12:0] strb_act;
   logic [2:0] n_drivers;

   vec_t tbl[$];
   vec_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;

   sap_control_sequencer dut (
      .clk               (clk),
      .reset             (reset),
      .run               (run),
      .bus_in            (bus_in),
      .alu_carry         (alu_carry),
      .alu_zero          (alu_zero),
      .pc_out            (pc_out),
      .ir_operand        (ir_operand),
      .pc_enable         (pc_enable),
      .ir_enable         (ir_enable),
      .ram_output_enable (ram_output_enable),
      .reg_a_enable      (reg_a_enable),
      .alu_enable        (alu_enable),
      .mar_load          (mar_load),
      .ir_load           (ir_load),
      .ram_write_enable  (ram_write_enable),
      .reg_a_load        (reg_a_load),
      .reg_b_load        (reg_b_load),
      .out_load          (out_load),
      .alu_subtract      (alu_subtract),
      .opcode            (opcode),
      .tstate            (tstate),
      .halted            (halted),
      .flag_c            (flag_c),
      .flag_z            (flag_z)
   );

   always #5 clk = ~clk;

   assign strb_act = {pc_enable, ir_enable, ram_output_enable, reg_a_enable, alu_enable,
                      mar_load, ir_load, ram_write_enable, reg_a_load, reg_b_load,
                      out_load, alu_subtract, halted};
   assign n_drivers = 3'(pc_enable) + 3'(ir_enable) + 3'(ram_output_enable)
                    + 3'(reg_a_enable) + 3'(alu_enable);

   // Datapath around the sequencer.
   assign alu_sum   = alu_subtract ? ({1'b0, reg_a} + {1'b0, ~reg_b} + 9'd1)
                                   : ({1'b0, reg_a} + {1'b0, reg_b});
   assign alu_carry = alu_sum[8];
   assign alu_zero  = (alu_sum[7:0] == 8'h00);

   always_comb begin
      bus_in = 8'h00;
      if (pc_enable)              bus_in = {4'h0, pc_out};
      else if (ir_enable)         bus_in = ir_operand;
      else if (ram_output_enable) bus_in = ram[mar];
      else if (reg_a_enable)      bus_in = reg_a;
      else if (alu_enable)        bus_in = alu_sum[7:0];
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) ram[i] <= prog[i];
         mar   <= 4'h0;
         reg_a <= 8'h00;
         reg_b <= 8'h00;
      end else begin
         if (mar_load)         mar <= bus_in[3:0];
         if (ram_write_enable) ram[mar] <= bus_in;
         if (reg_a_load)       reg_a <= bus_in;
         if (reg_b_load)       reg_b <= bus_in;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic add_vec(input logic r, input logic [2:0] ts, input logic [12:0] s,
                          input logic [3:0] pc, input logic [1:0] fl = 2'b00,
                          input logic oc = 1'b0, input logic [7:0] op = 8'h00);
      vec_t v;
      v.run = r; v.ts = ts; v.strb = s; v.pc = pc; v.flags = fl; v.oc = oc; v.opnd = op;
      tbl.push_back(v);
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 16; i++) prog[i] = 8'h00;
   endtask

   // Reset pulse starting at a falling edge; run is held high to show it is ignored.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      run   = 1'b1;
      #2;
      chk("reset_tstate", 32'(tstate), 32'd0);
      chk("reset_strobes", 32'(strb_act), 32'd0);
      chk("reset_pc", 32'(pc_out), 32'd0);
      #2;
      reset = 1'b0;
      run   = 1'b0;
   endtask

   task automatic apply_table(input string tname);
      vec_t e;
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         run = tbl[i].run;
         sb.push_back(tbl[i]);
         #2;
         e = sb.pop_front();
         chk($sformatf("%s[%0d].tstate", tname, i), 32'(tstate), 32'(e.ts));
         chk($sformatf("%s[%0d].strobes", tname, i), 32'(strb_act), 32'(e.strb));
         chk($sformatf("%s[%0d].pc", tname, i), 32'(pc_out), 32'(e.pc));
         chk($sformatf("%s[%0d].flags", tname, i), 32'({flag_c, flag_z}), 32'(e.flags));
         chk($sformatf("%s[%0d].one_bus_driver", tname, i), 32'(n_drivers <= 3'd1), 32'd1);
         if (e.oc) chk($sformatf("%s[%0d].ir_operand", tname, i), 32'(ir_operand), 32'(e.opnd));
      end
      tbl.delete();
   endtask

   // LDA 0xE then the fetch/decode of ADD 0xF (cycles 0..7 from IDLE).
   task automatic add_lda_prefix();
      add_vec(1, 0, 13'h0, 0);
      add_vec(1, 1, PCE | MARL, 0);
      add_vec(1, 2, ROE | IRL, 0);
      add_vec(1, 3, IRE | MARL, 1, 2'b00, 1, 8'h0E);
      add_vec(1, 4, ROE | RAL, 1);
      add_vec(1, 1, PCE | MARL, 1);
      add_vec(1, 2, ROE | IRL, 1);
      add_vec(1, 3, IRE | MARL, 2, 2'b00, 1, 8'h0F);
   endtask

   // ADD execute for 0xFF + 0x01 with run held, then fetch of the next word.
   task automatic add_add_tail();
      add_vec(1, 4, ROE | RBL, 2);
      add_vec(1, 5, ALE | RAL, 2);
      add_vec(1, 1, PCE | MARL, 2, 2'b11);
      add_vec(1, 2, ROE | IRL, 2, 2'b11);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      clear_prog();

      // LDI 5, then run dropped: the following NOP completes and the sequencer idles.
      prog[0] = 8'h55;
      do_reset();
      add_vec(1, 0, 13'h0, 0);
      add_vec(1, 1, PCE | MARL, 0);
      add_vec(1, 2, ROE | IRL, 0);
      add_vec(1, 3, IRE | RAL, 1, 2'b00, 1, 8'h05);
      add_vec(0, 1, PCE | MARL, 1);
      add_vec(0, 2, ROE | IRL, 1);
      add_vec(0, 3, 13'h0, 2);
      add_vec(0, 0, 13'h0, 2);
      add_vec(0, 0, 13'h0, 2);
      apply_table("ldi");
      chk("ldi_reg_a", 32'(reg_a), 32'h05);

      // LDA/ADD setting both flags, taken JZ, then HLT with run wiggling.
      clear_prog();
      prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'h87; prog[7] = 8'hF0;
      prog[14] = 8'hFF; prog[15] = 8'h01;
      do_reset();
      add_lda_prefix();
      add_add_tail();
      add_vec(1, 3, IRE, 3, 2'b11, 1, 8'h07);
      add_vec(1, 1, PCE | MARL, 7, 2'b11);
      add_vec(1, 2, ROE | IRL, 7, 2'b11);
      add_vec(1, 3, 13'h0, 8, 2'b11);
      for (int i = 0; i < 20; i++) add_vec(1'($urandom_range(0, 1)), 7, HLTD, 8, 2'b11);
      apply_table("add_jz_hlt");
      chk("add_reg_a", 32'(reg_a), 32'h00);

      // Run dropped in ADD T3, resume, JZ not taken with 3 + 1.
      clear_prog();
      prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'h87;
      prog[14] = 8'h03; prog[15] = 8'h01;
      do_reset();
      add_lda_prefix();
      add_vec(0, 4, ROE | RBL, 2);
      add_vec(0, 5, ALE | RAL, 2);
      add_vec(0, 0, 13'h0, 2);
      add_vec(0, 0, 13'h0, 2);
      add_vec(1, 0, 13'h0, 2);
      add_vec(1, 1, PCE | MARL, 2);
      add_vec(1, 2, ROE | IRL, 2);
      add_vec(0, 3, 13'h0, 3);
      add_vec(0, 0, 13'h0, 3);
      apply_table("run_drop_jz_nt");
      chk("run_drop_reg_a", 32'(reg_a), 32'h04);

      // NOP everywhere: PC wraps 15 -> 0 without halting.
      clear_prog();
      do_reset();
      add_vec(1, 0, 13'h0, 0);
      for (int k = 0; k <= 16; k++) begin
         add_vec(1, 1, PCE | MARL, 4'(k));
         add_vec(1, 2, ROE | IRL, 4'(k));
         add_vec(1, 3, 13'h0, 4'(k + 1));
      end
      apply_table("pc_wrap");

      // STA interrupted by an asynchronous reset between clock edges.
      clear_prog();
      prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'h4D;
      prog[14] = 8'hFF; prog[15] = 8'h01;
      do_reset();
      add_lda_prefix();
      add_add_tail();
      add_vec(1, 3, IRE | MARL, 3, 2'b11, 1, 8'h0D);
      add_vec(1, 4, RAE | RWE, 3, 2'b11);
      apply_table("sta_async");
      #1;
      reset = 1'b1;
      #1;
      chk("async_tstate", 32'(tstate), 32'd0);
      chk("async_pc", 32'(pc_out), 32'd0);
      chk("async_opcode", 32'(opcode), 32'd0);
      chk("async_ir_operand", 32'(ir_operand), 32'd0);
      chk("async_flags", 32'({flag_c, flag_z}), 32'd0);
      chk("async_ram_we", 32'(ram_write_enable), 32'd0);
      chk("async_strobes", 32'(strb_act), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run   = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
